fifo_uart_tx: RTL and testbench

Read-side consumer for the 8-bit, 32-deep FIFO. The block pops one word whenever the FIFO is non-empty and the block is enabled. It serialises each word onto a single UART-style line: start bit, data LSB first, optional parity, then stop bit(s). It sits between the FIFO's read port and an off-chip serial pin, and it drains the buffer that upstream logic fills.

---
 rtl/fifo_uart_tx.sv | 164 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx -- read-side consumer of a word FIFO that serialises each
// popped word onto a UART-style line: one start bit, the data bits LSB first,
// an optional even-parity bit, then one or more stop bits.
//
// Optional build macro: FIFO_UART_TX_PARITY_EN
//   If defined, a PARITY bit holding the XOR of the captured word follows the
//   data field. If undefined, there is no parity state or parity logic.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   enable      permits popping a new word (sampled only while idle)
//   fifo_empty  FIFO empty flag
//   fifo_data   word at the FIFO head, valid while fifo_empty is low
//   fifo_read   combinational pop strobe to the FIFO
//   tx          serial line, idles high
//   busy        high while a frame is in flight
//   tx_done     one-cycle pulse in the first idle cycle after a frame
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_read,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   // Bit index serves both the data field and the stop-bit count.
   localparam int BW = $clog2(DATA_WIDTH + 1);

   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

`ifdef FIFO_UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t                  state_q;
   logic [CW-1:0]           cnt_q;
   logic [BW-1:0]           idx_q;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic                    tx_q, tx_done_q;
   logic                    bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
   logic                    par_q;
`endif

   always_comb begin
      bit_end = (cnt_q == CNT_LAST);
      shift_d = shift_q >> 1;
   end

   // Pop and capture happen on the same edge, so the strobe is combinational.
   assign fifo_read = (state_q == IDLE) & enable & ~fifo_empty & ~reset;
   assign busy      = (state_q != IDLE);
   assign tx        = tx_q;
   assign tx_done   = tx_done_q;

   // tx is registered one state ahead: each transition loads the level of the
   // bit that the new state drives, so tx lines up with state_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         tx_done_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         tx_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               tx_q <= 1'b1;
               if (fifo_read) begin
                  shift_q <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                  par_q   <= ^fifo_data;
`endif
                  cnt_q   <= '0;
                  tx_q    <= 1'b0;
                  state_q <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  tx_q    <= shift_q[0];
                  state_q <= DATA;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  shift_q <= shift_d;
                  if (idx_q == DATA_LAST) begin
                     idx_q   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                     tx_q    <= par_q;
                     state_q <= PARITY;
`else
                     tx_q    <= 1'b1;
                     state_q <= STOP;
`endif
                  end else begin
                     idx_q <= idx_q + BW'(1);
                     tx_q  <= shift_d[0];
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  tx_q    <= 1'b1;
                  state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
`endif
            STOP: begin
               tx_q <= 1'b1;
               if (bit_end) begin
                  cnt_q <= '0;
                  if (idx_q == STOP_LAST) begin
                     idx_q     <= '0;
                     tx_done_q <= 1'b1;
                     state_q   <= IDLE;
                  end else begin
                     idx_q <= idx_q + BW'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               cnt_q   <= '0;
               idx_q   <= '0;
               tx_q    <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx at CLKS_PER_BIT=4. A queue models the FIFO;
// expected serial frames are built from the word as a list of bit levels.
module tb_fifo_uart_tx;
   localparam int DW  = 8;
   localparam int CPB = 4;
   localparam int SB  = 1;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int SPACING = (1 + DW + P + SB) * CPB + 1;

   logic          clk = 1'b0;
   logic          reset, enable;
   logic          fifo_empty, fifo_read, tx, busy, tx_done;
   logic [DW-1:0] fifo_data;

   int       n_pass  = 0;
   int       n_total = 0;
   int       cyc     = 0;
   bit       pop_seen = 1'b0;
   logic [DW-1:0] fq [$];
   int       pop_times [$];

   fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
      .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_data(fifo_data), .fifo_read(fifo_read), .tx(tx), .busy(busy),
      .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   // Pops are seen at the rising edge; the FIFO model applies them on the
   // following falling edge, well before the next rising edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      pop_seen <= fifo_read;
      if (fifo_read) pop_times.push_back(cyc);
   end

   always @(negedge clk) begin
      if (pop_seen && fq.size() != 0) void'(fq.pop_front());
      fifo_empty = (fq.size() == 0);
      fifo_data  = (fq.size() == 0) ? '0 : fq[0];
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Waits for a pop; returns at the first cycle of the start bit.
   task automatic wait_pop(input string nm, input int maxc);
      bit got = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (pop_seen) begin got = 1'b1; break; end
      end
      n_total++;
      if (got !== 1'b1) $display("FAIL %s: no pop within %0d cycles", nm, maxc);
      else n_pass++;
   endtask

   // Starting at the first start-bit cycle, checks every cycle of the frame,
   // then the tx_done cycle. Returns positioned at that tx_done cycle.
   task automatic check_frame(input logic [DW-1:0] w, input string nm);
      int lv [$];
      lv.push_back(0);
      for (int i = 0; i < DW; i++) lv.push_back(int'(w[i]));
      if (P == 1) lv.push_back(int'(^w));
      for (int s = 0; s < SB; s++) lv.push_back(1);
      for (int k = 0; k < lv.size() * CPB; k++) begin
         n_total++;
         if (tx !== lv[k / CPB][0])
            $display("FAIL %s tx cyc %0d: got %b want %b", nm, k, tx, lv[k / CPB][0]);
         else n_pass++;
         n_total++;
         if (busy !== 1'b1) $display("FAIL %s busy cyc %0d: got %b want 1", nm, k, busy);
         else n_pass++;
         n_total++;
         if (tx_done !== 1'b0) $display("FAIL %s tx_done cyc %0d: got %b want 0", nm, k, tx_done);
         else n_pass++;
         @(negedge clk);
      end
      n_total++;
      if (tx_done !== 1'b1) $display("FAIL %s tx_done end: got %b want 1", nm, tx_done);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0 || tx !== 1'b1)
         $display("FAIL %s idle end: busy %b tx %b want busy 0 tx 1", nm, busy, tx);
      else n_pass++;
   endtask

   task automatic check_idle(input string nm, input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         n_total++;
         if (fifo_read !== 1'b0 || tx !== 1'b1 || busy !== 1'b0)
            $display("FAIL %s cyc %0d: fifo_read %b tx %b busy %b want 0 1 0",
                     nm, i, fifo_read, tx, busy);
         else n_pass++;
      end
   endtask

   task automatic check_spacing(input string nm);
      for (int i = 1; i < pop_times.size(); i++) begin
         n_total++;
         if (pop_times[i] - pop_times[i-1] !== SPACING)
            $display("FAIL %s spacing %0d: got %0d want %0d", nm, i,
                     pop_times[i] - pop_times[i-1], SPACING);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b0;
      #2 reset = 1'b1;
      @(negedge clk);
      fq.push_back(8'hA5);
      enable = 1'b1;
      repeat (3) @(negedge clk);
      n_total++;
      if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0)
         $display("FAIL reset outputs: tx %b busy %b tx_done %b want 1 0 0", tx, busy, tx_done);
      else n_pass++;
      n_total++;
      if (fifo_read !== 1'b0) $display("FAIL reset fifo_read: got %b want 0", fifo_read);
      else n_pass++;
      enable = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      pop_times.delete();
      enable = 1'b1;
      wait_pop("single pop", 20);
      check_frame(8'hA5, "single A5");
      @(negedge clk);
      n_total++;
      if (pop_times.size() !== 1) $display("FAIL single pop count: got %0d want 1", pop_times.size());
      else n_pass++;
   endtask

   task automatic test_empty();
      enable = 1'b1;
      check_idle("empty", 200);
   endtask

   task automatic test_back_to_back();
      enable = 1'b0;
      @(negedge clk);
      fq.push_back(8'h01); fq.push_back(8'hFF);
      repeat (2) @(negedge clk);
      pop_times.delete();
      enable = 1'b1;
      wait_pop("b2b pop1", 20);
      check_frame(8'h01, "b2b 01");
      n_total++;
      if (fifo_read !== 1'b1) $display("FAIL b2b pop with tx_done: fifo_read %b want 1", fifo_read);
      else n_pass++;
      wait_pop("b2b pop2", 2);
      check_frame(8'hFF, "b2b FF");
      check_spacing("b2b");
      n_total++;
      if (pop_times.size() !== 2) $display("FAIL b2b pop count: got %0d want 2", pop_times.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      enable = 1'b1;
      @(negedge clk);
      fq.push_back(8'h5A);
      wait_pop("rstmid pop", 20);
      repeat ((1 + 3) * CPB + 1) @(negedge clk);
      n_total++;
      if (busy !== 1'b1) $display("FAIL rstmid busy before reset: got %b want 1", busy);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_total++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0)
         $display("FAIL rstmid async: tx %b busy %b fifo_read %b want 1 0 0", tx, busy, fifo_read);
      else n_pass++;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      pop_times.delete();
      check_idle("rstmid after", 60);
      n_total++;
      if (pop_times.size() !== 0) $display("FAIL rstmid pops: got %0d want 0", pop_times.size());
      else n_pass++;
   endtask

   task automatic test_enable_drop();
      logic [DW-1:0] w2 = DW'($urandom_range(0, 255));
      enable = 1'b0;
      @(negedge clk);
      fq.push_back(8'h3C); fq.push_back(w2);
      repeat (2) @(negedge clk);
      pop_times.delete();
      enable = 1'b1;
      wait_pop("endrop pop1", 20);
      enable = 1'b0;
      check_frame(8'h3C, "endrop 3C");
      n_total++;
      if (fifo_read !== 1'b0) $display("FAIL endrop no pop at done: fifo_read %b want 0", fifo_read);
      else n_pass++;
      check_idle("endrop held", 50);
      n_total++;
      if (pop_times.size() !== 1) $display("FAIL endrop pop count: got %0d want 1", pop_times.size());
      else n_pass++;
      enable = 1'b1;
      wait_pop("endrop pop2", 5);
      check_frame(w2, "endrop w2");
   endtask

   task automatic test_random();
      logic [DW-1:0] exp_q [$];
      enable = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         logic [DW-1:0] w = DW'($urandom_range(0, 255));
         fq.push_back(w); exp_q.push_back(w);
      end
      repeat (2) @(negedge clk);
      pop_times.delete();
      enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_pop("rand pop", (i == 0) ? 20 : 2);
         check_frame(exp_q[i], $sformatf("rand %0d", i));
      end
      check_spacing("rand");
      check_idle("rand drained", 10);
   endtask

`ifdef FIFO_UART_TX_PARITY_EN
   task automatic test_parity();
      enable = 1'b0;
      @(negedge clk);
      fq.push_back(8'h07); fq.push_back(8'h03);
      repeat (2) @(negedge clk);
      pop_times.delete();
      enable = 1'b1;
      wait_pop("par pop1", 20);
      repeat ((1 + DW) * CPB + 1) @(negedge clk);
      n_total++;
      if (tx !== 1'b1) $display("FAIL parity 07 bit: got %b want 1", tx);
      else n_pass++;
      repeat ((SB + 1) * CPB - 1) @(negedge clk);
      wait_pop("par pop2", 2);
      repeat ((1 + DW) * CPB + 1) @(negedge clk);
      n_total++;
      if (tx !== 1'b0) $display("FAIL parity 03 bit: got %b want 0", tx);
      else n_pass++;
      repeat ((SB + 1) * CPB - 1) @(negedge clk);
      n_total++;
      if (pop_times.size() !== 2 || pop_times[1] - pop_times[0] !== 45)
         $display("FAIL parity spacing: pops %0d want 2 spaced 45", pop_times.size());
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_empty();
      test_back_to_back();
      test_reset_mid();
      test_enable_drop();
      test_random();
`ifdef FIFO_UART_TX_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
